// File: rtl/scan_mux.sv
// Registered N-to-1 channel multiplexer: direct (address-selected) or round-robin
// scan selection, one-word output register with valid/ready handshake.
module scan_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       mode,
  input  logic [SELW-1:0]            address,
  input  logic [CHANNELS*WIDTH-1:0]  in_data,
  input  logic [CHANNELS-1:0]        in_valid,
  output logic [CHANNELS-1:0]        in_ack,
  output logic [WIDTH-1:0]           out_data,
  output logic [SELW-1:0]            out_channel,
  output logic                       out_valid,
  input  logic                       out_ready
);

  logic [SELW-1:0] last;
  logic [SELW-1:0] scan_sel;
  logic [SELW-1:0] sel;
  logic            scan_hit;
  logic            cand;
  logic            load;

  // Search last+1, last+2, ... wrapping; offset CHANNELS truncates back to last itself.
  always_comb begin
    scan_sel = last;
    scan_hit = 1'b0;
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      if (!scan_hit && in_valid[last + SELW'(i)]) begin
        scan_sel = last + SELW'(i);
        scan_hit = 1'b1;
      end
    end
  end

  always_comb begin
    sel  = mode ? scan_sel : address;
    cand = mode ? scan_hit : in_valid[address];
    load = cand && (!out_valid || out_ready);
  end

  always_comb begin
    in_ack = '0;
    if (load && reset_n)
      in_ack[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data    <= '0;
      out_channel <= '0;
      out_valid   <= 1'b0;
      last        <= '1;
    end else if (load) begin
      out_data    <= in_data[sel*WIDTH +: WIDTH];
      out_channel <= sel;
      out_valid   <= 1'b1;
      last        <= sel;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux (WIDTH=8, CHANNELS=4): vector table, corner
// sequences and randomized traffic against a behavioural model.
module tb_scan_mux;

  logic        clk;
  logic        reset_n;
  logic        mode;
  logic [1:0]  address;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ack;
  logic [7:0]  out_data;
  logic [1:0]  out_channel;
  logic        out_valid;
  logic        out_ready;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // model state
  bit       m_valid;
  bit [7:0] m_data;
  int       m_ch;
  int       m_last;

  scan_mux #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .address(address),
    .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack),
    .out_data(out_data), .out_channel(out_channel), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ch    = 0;
    m_last  = 3;
  endfunction

  function automatic void model_pick(input bit md, input int ad, input bit [3:0] v,
                                     output bit hit, output int s);
    int k;
    hit = 1'b0;
    s   = 0;
    if (!md) begin
      s   = ad;
      hit = v[ad];
    end else begin
      for (int o = 1; o <= 4; o++) begin
        k = (m_last + o) % 4;
        if (!hit && v[k]) begin
          hit = 1'b1;
          s   = k;
        end
      end
    end
  endfunction

  // Entered at posedge+1; returns at following posedge+1 with model updated.
  task automatic step(input bit md, input int ad, input bit [31:0] d, input bit [3:0] v,
                      input bit rdy, output logic [3:0] ack_seen);
    bit       hit;
    int       s;
    bit       ld;
    bit [3:0] eack;
    mode = md; address = ad[1:0]; in_data = d; in_valid = v; out_ready = rdy;
    #2;
    model_pick(md, ad, v, hit, s);
    ld   = hit && (!m_valid || rdy);
    eack = ld ? 4'(1 << s) : 4'b0000;
    ack_seen = in_ack;
    chk("in_ack", in_ack, eack);
    @(posedge clk);
    if (ld) begin
      m_valid = 1'b1;
      m_data  = d[s*8 +: 8];
      m_ch    = s;
      m_last  = s;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_channel", out_channel, m_ch);
  endtask

  // Entered at posedge+1; asserts reset between edges and releases it before the next edge.
  task automatic do_reset();
    reset_n = 1'b0;
    mode = 1'($urandom); address = 2'($urandom); in_data = $urandom;
    in_valid = 4'($urandom); out_ready = 1'($urandom);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_channel", out_channel, 2'd0);
    chk("rst_in_ack", in_ack, 4'b0000);
    model_reset();
    #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit       md;
    int       ad;
    bit [3:0] v;
    bit       rdy;
    bit [3:0] e_ack;
    bit       e_valid;
    bit [7:0] e_data;
    int       e_ch;
  } vec_t;

  vec_t        tbl[10];
  logic [3:0]  ack;
  logic [7:0]  held_data;
  logic [1:0]  held_ch;
  bit [31:0]   rd;

  initial begin
    // channel data: ch0=11 ch1=22 ch2=A5 ch3=44
    tbl[0] = '{0, 2, 4'b0100, 1, 4'b0100, 1, 8'hA5, 2};
    tbl[1] = '{0, 1, 4'b0100, 1, 4'b0000, 0, 8'hA5, 2};
    tbl[2] = '{1, 0, 4'b1111, 1, 4'b1000, 1, 8'h44, 3};
    tbl[3] = '{1, 0, 4'b1001, 0, 4'b0000, 1, 8'h44, 3};
    tbl[4] = '{1, 0, 4'b1001, 1, 4'b0001, 1, 8'h11, 0};
    tbl[5] = '{1, 0, 4'b1001, 1, 4'b1000, 1, 8'h44, 3};
    tbl[6] = '{1, 0, 4'b1001, 1, 4'b0001, 1, 8'h11, 0};
    tbl[7] = '{1, 0, 4'b0000, 1, 4'b0000, 0, 8'h11, 0};
    tbl[8] = '{0, 3, 4'b0000, 0, 4'b0000, 0, 8'h11, 0};
    tbl[9] = '{0, 1, 4'b0010, 0, 4'b0010, 1, 8'h22, 1};

    // power-on reset, checked before any clock edge
    reset_n = 1'b0;
    mode = 1'($urandom); address = 2'($urandom); in_data = $urandom;
    in_valid = 4'($urandom); out_ready = 1'($urandom);
    #2;
    chk("por_out_valid", out_valid, 1'b0);
    chk("por_out_data", out_data, 8'h00);
    chk("por_out_channel", out_channel, 2'd0);
    chk("por_in_ack", in_ack, 4'b0000);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;

    // vector table
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].md, tbl[i].ad, 32'h44A52211, tbl[i].v, tbl[i].rdy, ack);
      chk($sformatf("tbl%0d_ack", i), ack, tbl[i].e_ack);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_data", i), out_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_ch", i), out_channel, tbl[i].e_ch);
    end

    // scan fairness from reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 0, $urandom, 4'b1111, 1, ack);
      chk($sformatf("fair%0d_ch", i), out_channel, i % 4);
      chk($sformatf("fair%0d_valid", i), out_valid, 1'b1);
    end

    // skip/wrap with last=0
    step(1, 0, $urandom, 4'b1001, 1, ack);
    chk("wrap_first", out_channel, 2'd3);
    step(1, 0, $urandom, 4'b1001, 1, ack);
    chk("wrap_second", out_channel, 2'd0);

    // backpressure: outputs hold, inputs churn
    held_data = out_data;
    held_ch   = out_channel;
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom), $urandom_range(0, 3), $urandom, 4'($urandom) | 4'b0001, 0, ack);
      chk($sformatf("bp%0d_ack", i), ack, 4'b0000);
      chk($sformatf("bp%0d_data", i), out_data, held_data);
      chk($sformatf("bp%0d_ch", i), out_channel, held_ch);
      chk($sformatf("bp%0d_valid", i), out_valid, 1'b1);
    end
    step(1, 0, $urandom, 4'b0000, 1, ack);
    chk("bp_drain_valid", out_valid, 1'b0);

    // reset mid-operation
    step(0, 0, 32'h0000003C, 4'b0001, 0, ack);
    chk("mid_loaded", out_data, 8'h3C);
    do_reset();
    step(1, 0, $urandom, 4'b1111, 1, ack);
    chk("mid_first_ack", ack, 4'b0001);
    chk("mid_first_ch", out_channel, 2'd0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rd = $urandom;
      step(rd[0], rd[2:1], $urandom, ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom),
           ($urandom_range(0, 3) != 0), ack);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 SHALL have parameter WIDTH, 8, data bits per channel (>=1).
REQ-002 SHALL have parameter CHANNELS, 4, number of input channels (power of two, >=2); SELW = log2(CHANNELS).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mode  input  1  0 = direct (address-selected), 1 = round-robin scan.
REQ-006 SHALL have port address  input  SELW  channel select used in direct mode.
REQ-007 SHALL have port in_data  input  CHANNELS*WIDTH  flattened inputs; channel k at bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port in_valid  input  CHANNELS  per-channel data-valid.
REQ-009 SHALL have port in_ack  output  CHANNELS  one-hot, combinational; channel consumed this cycle.
REQ-010 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-011 SHALL have port out_channel  output  SELW  registered index of channel that produced out_data.
REQ-012 SHALL have port out_valid  output  1  out_data/out_channel hold a valid word.
REQ-013 SHALL have port out_ready  input  1  downstream accepts word when out_valid && out_ready at a rising edge.

Function
REQ-014 SHALL hold a one-word output register (out_data, out_channel, out_valid) and a SELW-bit last-grant pointer.
REQ-015 SHALL form sel: mode 0 -> address; mode 1 -> first k with in_valid[k]=1 searching last+1, last+2, ... wrapping modulo CHANNELS, last itself searched last.
REQ-016 SHALL define cand = in_valid[sel] (mode 1: any in_valid set); load = cand && (!out_valid || out_ready).
REQ-017 SHALL drive in_ack[sel]=1 in the cycle load=1, all other in_ack bits 0; in_ack=0 whenever load=0.
REQ-018 SHALL, on rising edge with load=1, set out_data <= in_data[sel], out_channel <= sel, out_valid <= 1, last <= sel (both modes).
REQ-019 SHALL, on rising edge with out_valid && out_ready && !load, clear out_valid; out_data/out_channel keep old values.
REQ-020 SHALL hold out_data, out_channel, out_valid, last unchanged when out_valid && !out_ready (backpressure); no ack issued.
REQ-021 SHALL give latency one cycle: ack in cycle N, word visible with out_valid after edge N; full throughput (one word per cycle) when out_ready held 1.
REQ-022 SHALL, in mode 0 with in_valid[address]=0, not load or ack even if other channels are valid.
REQ-023 SHALL, with in_valid all 0, issue no ack and let out_valid fall after consumption.
REQ-024 SHALL apply mode/address changes combinationally to the next load decision; last pointer is preserved across mode changes.
REQ-025 SHALL treat in_data/in_valid changes during backpressure as ignored until load.

Reset
REQ-026 SHALL, while reset_n=0, asynchronously force out_data=0, out_channel=0, out_valid=0, last=CHANNELS-1, independent of clk.
REQ-027 SHALL force in_ack=0 while reset_n=0.
REQ-028 SHALL, after reset_n rises, start scan search at channel 0; a word in flight at reset is discarded.

Verification (WIDTH=8, CHANNELS=4)
REQ-029 Reset: reset_n=0 with random inputs, no clock edge -> out_valid=0, out_data=8'h00, out_channel=0, in_ack=4'b0000.
REQ-030 Direct: mode=0, address=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1 -> in_ack=4'b0100 same cycle; after edge out_data=8'hA5, out_channel=2, out_valid=1; address=1 with in_valid=4'b0100 -> no ack.
REQ-031 Scan fairness: mode=1, in_valid=4'b1111, out_ready=1 from reset -> out_channel 0,1,2,3,0 on consecutive edges, out_valid continuously 1.
REQ-032 Skip/wrap: mode=1, last=0, in_valid=4'b1001 -> grants channel 3 then channel 0.
REQ-033 Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_data/out_channel stable, in_ack=0; out_ready=1 -> new word on next edge, or out_valid=0 if in_valid=0.
REQ-034 Reset mid-operation: out_valid=1, out_data=8'h3C, reset_n pulsed low between edges -> outputs zero immediately; after release with in_valid=4'b1111, mode=1, first grant channel 0.
